// File: rtl/usb_ram.sv
// usb_ram: simple dual-port synchronous RAM (one write port, one registered read port).
// Optional build macro USB_RAM_OUTREG_EN adds a second output stage (read latency 2).
module usb_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              rden,
  output logic [DATA_W-1:0] q
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("usb_ram: DEPTH must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  // No reset on the array so it maps onto a block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (wren) begin
      r_mem[wraddress] <= data;
    end
  end

`ifdef USB_RAM_OUTREG_EN
  logic [DATA_W-1:0] r_q_stage1;
  logic [DATA_W-1:0] r_q_stage2;

  // Stage 1 is the RAM's own read register; stage 2 is a free-running pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_stage1 <= '0;
      r_q_stage2 <= '0;
    end else begin
      if (rden) begin
        r_q_stage1 <= r_mem[rdaddress];
      end
      r_q_stage2 <= r_q_stage1;
    end
  end

  assign q = r_q_stage2;
`else
  logic [DATA_W-1:0] r_q;

  // The read samples the array before this edge's write lands, so a same-address
  // read-during-write returns the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (rden) begin
      r_q <= r_mem[rdaddress];
    end
  end

  assign q = r_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if ($isunknown(wren)) begin
      $error("usb_ram: wren is X/Z");
    end
    if ($isunknown(rden)) begin
      $error("usb_ram: rden is X/Z");
    end
  end
`endif

endmodule

// File: tb/tb_usb_ram.sv
// Self-checking bench for usb_ram: directed scenarios plus a randomized phase,
// all compared against a word-array reference model with a read-latency delay line.
module tb_usb_ram;

`ifdef USB_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] data;
  logic [12:0] wraddress;
  logic        wren;
  logic [12:0] rdaddress;
  logic        rden;
  logic [15:0] q;

  usb_ram dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .rden      (rden),
    .q         (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain word array plus the value waiting in the first output stage.
  logic [15:0] m_mem [8192];
  logic [15:0] m_stage;
  logic [15:0] exp_q;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic cyc(input logic rst, input logic wr, input logic [12:0] wa,
                     input logic [15:0] wd, input logic rd, input logic [12:0] ra,
                     input bit chk, input string tag);
    @(negedge clock);
    reset = rst; wren = wr; wraddress = wa; data = wd; rden = rd; rdaddress = ra;
    @(posedge clock);
    if (rst) begin
      m_stage = '0;
      exp_q   = '0;
    end else if (LAT == 2) begin
      exp_q = m_stage;
      if (rd) m_stage = m_mem[ra];
    end else if (rd) begin
      exp_q = m_mem[ra];
    end
    if (wr) m_mem[wa] = wd;
    #1;
    if (chk) begin
      n_chk++;
      assert (q === exp_q) else begin
        n_fail++;
        $error("FAIL %s: q=%h expected %h", tag, q, exp_q);
      end
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 13'd0, 16'd0, 1'b0, 13'd0, 1'b1, tag);
  endtask

  task automatic wr_word(input logic [12:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 13'd0, 1'b1, "write");
  endtask

  task automatic rd_word(input logic [12:0] a, input string tag);
    cyc(1'b0, 1'b0, 13'd0, 16'd0, 1'b1, a, 1'b1, tag);
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; rden = 1'b0; data = '0; wraddress = '0; rdaddress = '0;
    m_stage = '0;
    exp_q = '0;

    // 1: reset, then idle with rden low
    cyc(1'b1, 1'b0, 13'd0, 16'd0, 1'b0, 13'd0, 1'b1, "reset_q");
    cyc(1'b1, 1'b0, 13'd0, 16'd0, 1'b0, 13'd0, 1'b1, "reset_q");
    idle(5, "idle_after_reset");

    // 2: fill 0..19, read back
    for (int a = 0; a < 20; a++) wr_word(13'(a), 16'h1000 + 16'(a));
    for (int a = 0; a < 20; a++) rd_word(13'(a), "seq_read");
    idle(LAT, "seq_read_flush");

    // 3: read-during-write on the same address returns old data
    wr_word(13'd5, 16'hAAAA);
    cyc(1'b0, 1'b1, 13'd5, 16'h5555, 1'b1, 13'd5, 1'b1, "rdw_old");
    rd_word(13'd5, "rdw_next");
    idle(LAT, "rdw_flush");

    // 4: independent write and read addresses in one cycle
    wr_word(13'd7, 16'h0007);
    cyc(1'b0, 1'b1, 13'd100, 16'hABCD, 1'b1, 13'd7, 1'b1, "indep_read");
    rd_word(13'd100, "indep_write");
    idle(LAT, "indep_flush");

    // 5: address wrap 8191 -> 0
    wr_word(13'd8191, 16'hBEEF);
    wr_word(13'd0, 16'hCAFE);
    rd_word(13'd8191, "wrap_top");
    rd_word(13'd0, "wrap_zero");
    idle(LAT, "wrap_flush");

    // 6: hold with rden low, reset clears q, memory survives reset
    wr_word(13'd3, 16'h0003);
    rd_word(13'd3, "hold_read");
    idle(LAT, "hold_settle");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 13'd0, 16'd0, 1'b0, 13'($urandom), 1'b1, "hold_q");
    cyc(1'b1, 1'b1, 13'd50, 16'h7E57, 1'b1, 13'd3, 1'b1, "reset_clears");
    rd_word(13'd3, "reread_after_reset");
    rd_word(13'd50, "write_during_reset");
    idle(LAT, "reread_flush");

    // Randomized mix over a small pool so same-address collisions are frequent
    for (int a = 0; a < 16; a++) wr_word(13'd200 + 13'(a), 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
          1'($urandom), 13'd200 + 13'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom), 13'd200 + 13'($urandom_range(0, 15)), 1'b1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
